// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus: tag field layout, requester indices, broadcast packet.
package cdb_pkg;

  localparam int TAG_VALID_BIT = 7;
  localparam int TAG_MEM_BIT   = 6;
  localparam int TAG_ADD_BIT   = 5;
  localparam int TAG_MUL_BIT   = 4;

  localparam int REQ_MEM = 0;
  localparam int REQ_ADD = 1;
  localparam int REQ_MUL = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [7:0]  tag;
  } cdb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic found;
  int   j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant among result producers, registered broadcast of the winner.
// Optional statistics counters are built when CDB_ARB_STATS_EN is defined.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 8,
  parameter int STATS_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic [NUM_REQ-1:0]         req_grant,
  output logic                       cdb_valid,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic                       err_bad_tag
`ifdef CDB_ARB_STATS_EN
  ,output logic [NUM_REQ*STATS_W-1:0] stat_grants
  ,output logic [STATS_W-1:0]         stat_stalls
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req_eff, grant;
  logic [IW-1:0]      gidx, rr_ptr_q, rr_ptr_d;
  logic               gany;
  logic [DATA_W-1:0]  data_sel, cdb_data_q, cdb_data_d;
  logic [TAG_W-1:0]   tag_sel, cdb_tag_q, cdb_tag_d;
  logic               cdb_valid_q, cdb_valid_d, err_q, err_d;

  // Nothing is eligible while disabled or held in reset, so the grant doubles as a safe ack.
  assign req_eff = (en && reset) ? req_valid : '0;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i   (req_eff),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .any_o   (gany)
  );

  assign req_grant = grant;

  always_comb begin
    data_sel = '0;
    tag_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        data_sel = data_sel | req_data[i*DATA_W +: DATA_W];
        tag_sel  = tag_sel  | req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    cdb_valid_d = gany;
    cdb_data_d  = gany ? data_sel : cdb_data_q;
    cdb_tag_d   = gany ? tag_sel  : cdb_tag_q;
    rr_ptr_d    = rr_ptr_q;
    if (gany) begin
      rr_ptr_d = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
    end
    err_d = err_q | (gany & ~tag_sel[TAG_W-1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_tag_q   <= '0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_tag_q   <= cdb_tag_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_data    = cdb_data_q;
  assign cdb_tag     = cdb_tag_q;
  assign err_bad_tag = err_q;

`ifdef CDB_ARB_STATS_EN
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + STATS_W'(1);
  endfunction

  logic [NUM_REQ-1:0][STATS_W-1:0] grants_q, grants_d;
  logic [STATS_W-1:0]              stalls_q, stalls_d;

  // A stall is any eligible request left waiting this cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grants_d[i] = grant[i] ? sat_inc(grants_q[i]) : grants_q[i];
    end
    stalls_d = (en && |(req_valid & ~grant)) ? sat_inc(stalls_q) : stalls_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      grants_q <= grants_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_grants = grants_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a circular-search reference model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int SW = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR*TW-1:0] req_tag = '0;
  logic [NR-1:0]    req_grant;
  logic             cdb_valid;
  logic [DW-1:0]    cdb_data;
  logic [TW-1:0]    cdb_tag;
  logic             err_bad_tag;
`ifdef CDB_ARB_STATS_EN
  logic [NR*SW-1:0] stat_grants;
  logic [SW-1:0]    stat_stalls;
`endif

  cdb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TAG_W(TW), .STATS_W(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_tag     (req_tag),
    .req_grant   (req_grant),
    .cdb_valid   (cdb_valid),
    .cdb_data    (cdb_data),
    .cdb_tag     (cdb_tag),
    .err_bad_tag (err_bad_tag)
`ifdef CDB_ARB_STATS_EN
    ,.stat_grants (stat_grants)
    ,.stat_stalls (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference state
  int            m_ptr;
  bit            m_valid;
  logic [DW-1:0] m_data;
  logic [TW-1:0] m_tag;
  bit            m_err;
  int            m_gr[NR];
  int            m_st;
  int            waitc[NR];
  logic [NR-1:0] last_grant;

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_tag = '0; m_err = 0; m_st = 0;
    for (int i = 0; i < NR; i++) begin
      m_gr[i] = 0;
      waitc[i] = 0;
    end
  endtask

  function automatic int ref_pick();
    int i;
    if (!reset || !en) return -1;
    for (int k = 0; k < NR; k++) begin
      i = (m_ptr + k) % NR;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Called just after a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    int g;
    logic [NR-1:0] eg;
    #1;
    g = ref_pick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("grant", req_grant, eg);
    last_grant = eg;
    for (int i = 0; i < NR; i++) begin
      if (reset && en && req_valid[i] && !req_grant[i]) begin
        waitc[i]++;
        chk("fairness", waitc[i] > NR - 1, 0);
      end else begin
        waitc[i] = 0;
      end
    end
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = req_data[g*DW +: DW];
        m_tag   = req_tag[g*TW +: TW];
        if (!m_tag[TW-1]) m_err = 1;
        m_ptr = (g == NR - 1) ? 0 : g + 1;
        if (m_gr[g] < (1 << SW) - 1) m_gr[g]++;
      end else begin
        m_valid = 0;
      end
      if (en && ((req_valid & ~eg) != 0) && m_st < (1 << SW) - 1) m_st++;
    end
    @(negedge clk);
    chk("cdb_valid", cdb_valid, m_valid);
    chk("cdb_data", cdb_data, m_data);
    chk("cdb_tag", cdb_tag, m_tag);
    chk("err_bad_tag", err_bad_tag, m_err);
`ifdef CDB_ARB_STATS_EN
    for (int i = 0; i < NR; i++) chk("stat_grants", stat_grants[i*SW +: SW], SW'(m_gr[i]));
    chk("stat_stalls", stat_stalls, SW'(m_st));
`endif
  endtask

  task automatic set_req(input int u, input logic [DW-1:0] d, input logic [TW-1:0] t);
    req_valid[u] = 1'b1;
    req_data[u*DW +: DW] = d;
    req_tag[u*TW +: TW] = t;
  endtask

  task automatic mid_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_data", cdb_data, 0);
    chk("rst_cdb_tag", cdb_tag, 0);
    chk("rst_err", err_bad_tag, 0);
    chk("rst_grant", req_grant, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [NR-1:0] seq[6];

  initial begin
    model_reset();
    // Reset with all requests pending
    en = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, DW'(32'hA000 + i), 8'h80 | TW'(i));
    #1 reset = 1'b0;
    #1;
    chk("t1_grant_in_reset", req_grant, 0);
    chk("t1_cdb_valid", cdb_valid, 0);
    chk("t1_cdb_tag", cdb_tag, 0);
    @(negedge clk);
    step();
    reset = 1'b1;
    step();
    chk("t1_first_grant", last_grant, 3'b001);
    req_valid = '0;
    step();

    // Single mem request
    set_req(REQ_MEM, 32'h1234, 8'hC3);
    step();
    chk("t2_grant", last_grant, 3'b001);
    chk("t2_valid", cdb_valid, 1);
    chk("t2_data", cdb_data, 32'h1234);
    chk("t2_tag", cdb_tag, 8'hC3);
    req_valid = '0;
    step();
    chk("t2_valid_drop", cdb_valid, 0);

    // Park the pointer at 0, then hold all three
    set_req(REQ_MUL, 32'h55, 8'h91);
    step();
    req_valid = '0;
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NR; i++) set_req(i, $urandom, 8'h80 | 8'($urandom_range(0, 127)));
      step();
      chk("t3_seq", last_grant, seq[c]);
      chk("t3_valid", cdb_valid, 1);
    end
    req_valid = '0;

    // Pointer after a grant to unit 1
    set_req(REQ_ADD, 32'h11, 8'hA1);
    step();
    set_req(REQ_MEM, 32'h22, 8'hC2);
    step();
    chk("t4_grant0", last_grant, 3'b001);
    req_valid[REQ_MEM] = 1'b0;
    step();
    chk("t4_grant1", last_grant, 3'b010);
    req_valid = 3'b000;
    for (int i = 0; i < NR; i++) set_req(i, $urandom, 8'h88);
    step();
    chk("t4_ptr_at_2", last_grant, 3'b100);
    req_valid = '0;

    // Enable low freezes arbitration
    set_req(REQ_MUL, 32'h77, 8'h92);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_nogrant", last_grant, 0);
      chk("t5_valid", cdb_valid, 0);
    end
    en = 1'b1;
    step();
    chk("t5_grant2", last_grant, 3'b100);
    req_valid = '0;

    // Tag with the valid bit clear
    set_req(REQ_ADD, 32'hBEEF, 8'h43);
    step();
    chk("t6_tag", cdb_tag, 8'h43);
    chk("t6_err", err_bad_tag, 1);
    req_valid = '0;
    step();
    step();
    chk("t6_err_sticky", err_bad_tag, 1);
    mid_reset();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (last_grant[i]) req_valid[i] = 1'b0;
        if (req_valid[i]) begin
          if ($urandom_range(0, 99) < 3) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 45) begin
          set_req(i, $urandom, {($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0, 7'($urandom)});
        end
      end
      en = ($urandom_range(0, 99) < 85);
      step();
      if (c == 200) begin
        mid_reset();
        last_grant = '0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d want=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
